mem_arbiter: RTL

Two-requester arbiter that shares one single-port backing-memory interface between the instruction-fetch miss path (read-only) and the data-cache miss/write path. It sits between the L1 caches and backing memory. It serialises accesses through a three-state FSM, arbitrates ties (round-robin or fixed priority), returns each response with a one-cycle ready pulse, and aborts any access whose memory acknowledge does not arrive within a bounded number of cycles.

---
 rtl/mem_arbiter.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-requester (I-fetch / D-side) arbiter onto one single-port backing memory, with ack timeout.
// Optional macro MEM_ARBITER_ROUND_ROBIN_EN selects round-robin ties; default is fixed D priority.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_ready,
    output logic [DATA_WIDTH-1:0] i_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_ready,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  err,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    typedef enum logic {OWN_I = 1'b0, OWN_D = 1'b1} owner_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t                state_q, state_d;
    owner_t                owner_q, owner_d;
    owner_t                last_grant_q, last_grant_d;
    owner_t                grant;
    logic [7:0]            cnt_q, cnt_d;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                  i_ready_q, i_ready_d;
    logic                  d_ready_q, d_ready_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;

    always_comb begin
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
        if (i_req && d_req) begin
            grant = (last_grant_q == OWN_I) ? OWN_D : OWN_I;
        end else begin
            grant = d_req ? OWN_D : OWN_I;
        end
`else
        grant = d_req ? OWN_D : OWN_I;
`endif
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        i_ready_d    = 1'b0;
        d_ready_d    = 1'b0;
        err_d        = 1'b0;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;

        case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    owner_d   = grant;
                    mem_req_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = BUSY;
                    if (grant == OWN_D) begin
                        mem_we_d    = d_we;
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wdata;
                    end else begin
                        mem_we_d    = 1'b0;
                        mem_addr_d  = i_addr;
                        mem_wdata_d = '0;
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt_q + 8'd1;
                // An ack in the final allowed cycle still completes normally.
                if (mem_ack || cnt_q == CNT_LAST) begin
                    mem_req_d = 1'b0;
                    cnt_d     = '0;
                    err_d     = !mem_ack;
                    state_d   = DONE;
                    if (owner_q == OWN_I) begin
                        i_ready_d = 1'b1;
                        i_rdata_d = mem_ack ? mem_rdata : '0;
                    end else begin
                        d_ready_d = 1'b1;
                        if (!mem_we_q) begin
                            d_rdata_d = mem_ack ? mem_rdata : '0;
                        end
                    end
                end
            end
            DONE: begin
                last_grant_d = owner_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            owner_q      <= OWN_I;
            last_grant_q <= OWN_I;
            cnt_q        <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            i_ready_q    <= 1'b0;
            d_ready_q    <= 1'b0;
            err_q        <= 1'b0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            i_ready_q    <= i_ready_d;
            d_ready_q    <= d_ready_d;
            err_q        <= err_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign i_ready   = i_ready_q;
    assign d_ready   = d_ready_q;
    assign err       = err_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;

endmodule
